sdram_refresh_timer: RTL and testbench

- CLK7-domain refresh scheduler for the chip-RAM SDRAM controller.
- Counts 7 MHz ticks since the last AUTOREFRESH command and drives graded request levels (REQ, URGENT, OVERDUE) into the CLK80 controller.
- The controller issuing AUTOREFRESH drives REF_RESET, which restarts the interval.
- CLK7 is used because it runs regardless of CPU speed or configuration.

---
 rtl/sdram_refresh_timer.sv | 213 +++++++++++++++++++++
 tb/tb_sdram_refresh_timer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sdram_refresh_timer.sv
// CLK7-domain refresh scheduler: counts ticks since the last AUTOREFRESH and raises graded
// REQ/URGENT/OVERDUE levels. Optional opportunistic EARLY request enabled by REFRESH_EARLY_EN.
`timescale 1ns / 100ps

module sdram_refresh_timer #(
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned REQ_COUNT     = 52,
    parameter int unsigned URGENT_COUNT  = 56,
    parameter int unsigned OVERDUE_COUNT = 60,
    parameter int unsigned EARLY_COUNT   = 40
) (
    input  logic             CLK7,
    input  logic             REF_RESET,
    input  logic             RAM_CONFIGURED,
    input  logic             nRAS0,
    input  logic             nRAS1,
    output logic             REFRESH_REQ,
    output logic             REFRESH_URGENT,
    output logic             REFRESH_OVERDUE,
    output logic [CNT_W-1:0] REF_COUNT,
    output logic [2:0]       REF_STATE
);

`ifdef REFRESH_EARLY_EN
    typedef enum logic [2:0] {
        StIdle    = 3'b000,
        StCount   = 3'b001,
        StReq     = 3'b010,
        StUrgent  = 3'b011,
        StOverdue = 3'b100,
        StEarly   = 3'b101
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle    = 3'b000,
        StCount   = 3'b001,
        StReq     = 3'b010,
        StUrgent  = 3'b011,
        StOverdue = 3'b100
    } state_e;
`endif

    localparam logic [CNT_W-1:0] CntSat     = '1;
    localparam logic [CNT_W-1:0] ReqThr     = CNT_W'(REQ_COUNT);
    localparam logic [CNT_W-1:0] UrgentThr  = CNT_W'(URGENT_COUNT);
    localparam logic [CNT_W-1:0] OverdueThr = CNT_W'(OVERDUE_COUNT);

    // Elaboration-time ordering checks on the thresholds.
    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_width
        $error("sdram_refresh_timer: CNT_W must be in 1..31");
    end
    if (!(REQ_COUNT < URGENT_COUNT && URGENT_COUNT < OVERDUE_COUNT)) begin : g_bad_order
        $error("sdram_refresh_timer: need REQ_COUNT < URGENT_COUNT < OVERDUE_COUNT");
    end
    if (longint'(OVERDUE_COUNT) >= (longint'(1) << CNT_W)) begin : g_bad_range
        $error("sdram_refresh_timer: OVERDUE_COUNT must be below 2**CNT_W");
    end

    // RAM_CONFIGURED synchronizer
    logic cfg_meta_q, cfg_s_q;

    always_ff @(posedge CLK7 or posedge REF_RESET) begin
        if (REF_RESET) begin
            cfg_meta_q <= 1'b0;
            cfg_s_q    <= 1'b0;
        end else begin
            cfg_meta_q <= RAM_CONFIGURED;
            cfg_s_q    <= cfg_meta_q;
        end
    end

`ifdef REFRESH_EARLY_EN
    localparam logic [CNT_W-1:0] EarlyThr = CNT_W'(EARLY_COUNT);

    if (!(EARLY_COUNT < REQ_COUNT)) begin : g_bad_early
        $error("sdram_refresh_timer: need EARLY_COUNT < REQ_COUNT");
    end

    logic idle_meta_q, idle_s_q, idle_hist_q;
    logic agnus_idle_ok;

    always_ff @(posedge CLK7 or posedge REF_RESET) begin
        if (REF_RESET) begin
            idle_meta_q <= 1'b0;
            idle_s_q    <= 1'b0;
            idle_hist_q <= 1'b0;
        end else begin
            idle_meta_q <= nRAS0 & nRAS1;
            idle_s_q    <= idle_meta_q;
            idle_hist_q <= idle_s_q;
        end
    end

    // Agnus idle seen on two consecutive synchronized samples.
    assign agnus_idle_ok = idle_s_q & idle_hist_q;
`else
    localparam int unsigned unused_early_count = EARLY_COUNT;
    logic unused_nras;
    assign unused_nras = nRAS0 & nRAS1;
`endif

    // Interval counter and FSM
    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             req_q, req_d;
    logic             urgent_q, urgent_d;
    logic             overdue_q, overdue_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;

        if (!cfg_s_q) begin
            state_d = StIdle;
            count_d = '0;
        end else begin
            if (count_q != CntSat) begin
                count_d = count_q + 1'b1;
            end

            // Thresholds are compared against the next count so outputs track REF_COUNT.
            unique case (state_q)
                StIdle: begin
                    state_d = StCount;
                end
                StCount: begin
                    if (count_d >= ReqThr) begin
                        state_d = StReq;
`ifdef REFRESH_EARLY_EN
                    end else if (count_d >= EarlyThr && agnus_idle_ok) begin
                        state_d = StEarly;
`endif
                    end
                end
`ifdef REFRESH_EARLY_EN
                StEarly: begin
                    if (count_d >= ReqThr) begin
                        state_d = StReq;
                    end
                end
`endif
                StReq: begin
                    if (count_d >= UrgentThr) begin
                        state_d = StUrgent;
                    end
                end
                StUrgent: begin
                    if (count_d >= OverdueThr) begin
                        state_d = StOverdue;
                    end
                end
                StOverdue: begin
                    state_d = StOverdue;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        req_d     = 1'b0;
        urgent_d  = 1'b0;
        overdue_d = 1'b0;

        unique case (state_d)
`ifdef REFRESH_EARLY_EN
            StEarly: begin
                req_d = 1'b1;
            end
`endif
            StReq: begin
                req_d = 1'b1;
            end
            StUrgent: begin
                req_d    = 1'b1;
                urgent_d = 1'b1;
            end
            StOverdue: begin
                req_d     = 1'b1;
                urgent_d  = 1'b1;
                overdue_d = 1'b1;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK7 or posedge REF_RESET) begin
        if (REF_RESET) begin
            state_q   <= StIdle;
            count_q   <= '0;
            req_q     <= 1'b0;
            urgent_q  <= 1'b0;
            overdue_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            req_q     <= req_d;
            urgent_q  <= urgent_d;
            overdue_q <= overdue_d;
        end
    end

    assign REFRESH_REQ     = req_q;
    assign REFRESH_URGENT  = urgent_q;
    assign REFRESH_OVERDUE = overdue_q;
    assign REF_COUNT       = count_q;
    assign REF_STATE       = state_q;

endmodule

// File: tb/tb_sdram_refresh_timer.sv
// Directed bench for sdram_refresh_timer (default build): interval timing, saturation,
// short asynchronous reset pulse, and RAM_CONFIGURED gating.
`timescale 1ns / 100ps

module tb_sdram_refresh_timer;

    logic       CLK7;
    logic       REF_RESET;
    logic       RAM_CONFIGURED;
    logic       nRAS0;
    logic       nRAS1;
    logic       REFRESH_REQ;
    logic       REFRESH_URGENT;
    logic       REFRESH_OVERDUE;
    logic [7:0] REF_COUNT;
    logic [2:0] REF_STATE;

    int n_cmp;
    int n_err;

    sdram_refresh_timer dut (
        .CLK7            (CLK7),
        .REF_RESET       (REF_RESET),
        .RAM_CONFIGURED  (RAM_CONFIGURED),
        .nRAS0           (nRAS0),
        .nRAS1           (nRAS1),
        .REFRESH_REQ     (REFRESH_REQ),
        .REFRESH_URGENT  (REFRESH_URGENT),
        .REFRESH_OVERDUE (REFRESH_OVERDUE),
        .REF_COUNT       (REF_COUNT),
        .REF_STATE       (REF_STATE)
    );

    initial begin
        CLK7 = 1'b0;
        forever #70 CLK7 = ~CLK7;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int req, input int urg, input int ovd,
                              input int st, input int cnt);
        check_eq({tag, "_req"}, 32'(REFRESH_REQ), req);
        check_eq({tag, "_urg"}, 32'(REFRESH_URGENT), urg);
        check_eq({tag, "_ovd"}, 32'(REFRESH_OVERDUE), ovd);
        check_eq({tag, "_state"}, 32'(REF_STATE), st);
        check_eq({tag, "_count"}, 32'(REF_COUNT), cnt);
    endtask

    // Step to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge CLK7);
        #1;
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        nRAS0          = 1'b1;
        nRAS1          = 1'b1;
        RAM_CONFIGURED = 1'b1;
        REF_RESET      = 1'b1;

        // Reset held, then release mid-cycle with RAM configured.
        repeat (3) tick();
        check_outs("in_reset", 0, 0, 0, 0, 0);
        #30 REF_RESET = 1'b0;

        for (int e = 1; e <= 54; e++) begin
            tick();
            check_eq("run_count", 32'(REF_COUNT), (e <= 2) ? 0 : e - 2);
            if (e == 2) check_eq("sync_idle", 32'(REF_STATE), 0);
            if (e == 3) check_eq("enter_count", 32'(REF_STATE), 1);
            if (e == 53) check_outs("pre_req", 0, 0, 0, 1, 51);
            if (e == 54) check_outs("req_on", 1, 0, 0, 2, 52);
        end

        for (int c = 53; c <= 60; c++) begin
            tick();
            if (c == 55) check_outs("pre_urg", 1, 0, 0, 2, 55);
            if (c == 56) check_outs("urg_on", 1, 1, 0, 3, 56);
            if (c == 59) check_outs("pre_ovd", 1, 1, 0, 3, 59);
            if (c == 60) check_outs("ovd_on", 1, 1, 1, 4, 60);
        end

        repeat (195) tick();
        check_outs("sat", 1, 1, 1, 4, 255);
        repeat (5) tick();
        check_outs("sat_hold", 1, 1, 1, 4, 255);

        // Short reset pulse while in REQ.
        REF_RESET = 1'b1;
        tick();
        #30 REF_RESET = 1'b0;
        repeat (56) tick();
        check_outs("at54", 1, 0, 0, 2, 54);
        REF_RESET = 1'b1;
        #5;
        check_outs("pulse_in", 0, 0, 0, 0, 0);
        #7.5 REF_RESET = 1'b0;
        #5;
        check_outs("pulse_out", 0, 0, 0, 0, 0);
        for (int e = 1; e <= 54; e++) begin
            tick();
            if (e == 53) check_outs("re_pre_req", 0, 0, 0, 1, 51);
            if (e == 54) check_outs("re_req_on", 1, 0, 0, 2, 52);
        end

        // RAM not configured: stays idle until raised.
        REF_RESET      = 1'b1;
        RAM_CONFIGURED = 1'b0;
        tick();
        #30 REF_RESET = 1'b0;
        repeat (20) tick();
        check_outs("unconfig", 0, 0, 0, 0, 0);
        RAM_CONFIGURED = 1'b1;
        tick();
        tick();
        check_outs("cfg_sync", 0, 0, 0, 0, 0);
        tick();
        check_outs("cfg_count", 0, 0, 0, 1, 1);

        // Drop configuration while URGENT.
        repeat (56) tick();
        check_outs("urg57", 1, 1, 0, 3, 57);
        RAM_CONFIGURED = 1'b0;
        repeat (3) tick();
        check_outs("cfg_drop", 0, 0, 0, 0, 0);
        repeat (4) tick();
        check_outs("cfg_drop_hold", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
